aes_stream_wrapper: RTL and testbench
=====================================

Name: aes_stream_wrapper

Overview:
- Streaming valid/ready wrapper around the fixed-latency, non-stallable AES-128 pipeline core (aes_128 datapath).
- Accepts one plaintext/key beat per cycle and drives it to the core.
- Tracks in-flight beats with a valid/tag shift register and captures core results into an output FIFO.
- Credit-based admission guarantees the FIFO never overflows, because the core cannot be stalled.

Parameters:
- CORE_LAT, 11, core latency in cycles from core input sample edge to result on core_out (aes_128 = 1 input reg + 9 rounds + final).
- DEPTH, 16, output FIFO entries; must be ≥1; full throughput requires DEPTH ≥ CORE_LAT+2.
- TAG_W, 8, width of user tag carried alongside each beat (not through core).
- DATA_W, 128, block/key width (fixed 128 for aes_128; parameter kept for AES-192/256 cores).

Ports:
- clk  in  1  clock, all logic posedge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  wrapper can accept beat.
- in_state  in  DATA_W  plaintext.
- in_key  in  DATA_W  key for this beat.
- in_tag  in  TAG_W  user tag.
- core_state  out  DATA_W  to core state input.
- core_key  out  DATA_W  to core key input.
- core_out  in  DATA_W  core ciphertext.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  ciphertext at FIFO head.
- out_tag  out  TAG_W  tag at FIFO head.
- occupancy  out  $clog2(DEPTH+1)  reserved credits (in-flight + stored).
- err_ovf  out  1  sticky: core result arrived while FIFO full.

Behaviour:
- Reset (rst=0, async):
  - valid/tag pipe cleared; FIFO pointers and count = 0; occupancy = 0; err_ovf = 0.
  - Therefore in_ready = 1 (DEPTH≥1) and out_valid = 0 immediately; out_data/out_tag undefined-but-stable (hold zero).
  - In-flight beats are discarded; core results emerging after reset release are ignored because the pipe is cleared.
- Accept: acc = in_valid && in_ready.
  - in_ready = (occupancy < DEPTH); purely registered-state derived, no combinational path from in_valid or out_ready.
  - core_state = in_state and core_key = in_key, driven combinationally; the core samples every edge, and only accepted beats are tracked.
- Valid pipe: CORE_LAT stages of {valid, tag}.
  - Stage 0 loads {acc, in_tag} at the accept edge.
  - Exit stage valid is true during cycle t+CORE_LAT for a beat accepted at edge t; core_out is valid in that same cycle.
- FIFO write: on exit-valid, {core_out, exit_tag} is written at the end of cycle t+CORE_LAT. out_valid rises in cycle t+CORE_LAT+1. Minimum accept-to-out_valid latency is CORE_LAT+1 cycles.
- Pop: pop = out_valid && out_ready; head advances at the edge.
- Occupancy:
  - +1 on acc, −1 on pop, unchanged when both occur in the same cycle.
  - Never exceeds DEPTH, never negative.
- Simultaneous write and pop on a full FIFO is legal; count is unchanged.
- FIFO empty with write and pop in the same cycle: pop is not possible because out_valid=0; the write lands and out_valid asserts next cycle. No bypass path.
- Pointers wrap modulo DEPTH; non-power-of-2 DEPTH must be supported (explicit compare-and-wrap).
- err_ovf: set if exit-valid occurs while count==DEPTH and there is no pop; the write is dropped. Unreachable by construction; this is a hardening check. Cleared only by reset.
- Ordering is strictly FIFO; tags are returned with their own ciphertext.
- out_data/out_tag must be held stable while out_valid && !out_ready.

Decomposition:
- Package aes_stream_pkg: DATA_W default, AES128_LAT=11 constant, credit-width function clog2p1(DEPTH).
- One sub-module: stream_fifo (parameterised DEPTH, width DATA_W+TAG_W, registered count, no bypass), reusable elsewhere in the codebase.
- Valid/tag delay line and credit counter stay in the top.

Test Plan:
- FIPS-197 vector with real aes_128 core: key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff, tag 0x5A, accepted at cycle 0 -> out_valid at cycle 12 with out_data 69c4e0d86a7b0430d8cdb78070b4c55a and out_tag 0x5A.
- Streaming with DEPTH=16, CORE_LAT=11: 40 back-to-back beats, out_ready=1 -> in_ready never deasserts, 40 outputs in tag order 0..39, one per cycle after the initial 12-cycle gap.
- Backpressure with DEPTH=4: out_ready=0, in_valid=1 continuous -> exactly 4 beats accepted, then in_ready=0 and occupancy=4. Raising out_ready drains in order; each pop re-enables one accept the next cycle; err_ovf stays 0.
- Full-FIFO simultaneous write/pop with DEPTH=CORE_LAT+2, random out_ready at 50% over 1000 beats -> scoreboard matches every beat, occupancy ≤ DEPTH, err_ovf=0.
- Reset mid-operation: 6 beats in flight, rst pulsed low for 1 cycle asynchronously between edges -> out_valid=0 and occupancy=0 immediately; stale core results are never written; the next accepted beat emerges after exactly CORE_LAT+1 cycles.
- Odd depth DEPTH=5 wrap: 12 beats with alternating out_ready -> pointers wrap correctly and data is returned in order.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared constants and helpers for the AES streaming wrapper.
// Imported by the wrapper top and its FIFO.
package aes_stream_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int AES128_LAT = 11;

  function automatic int clog2p1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Circular FIFO with registered count, arbitrary depth, no bypass.
// A write into a full FIFO lands only if a pop frees a slot that cycle.
module stream_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 136
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = clog2p1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             full;
  logic             rd_ok;
  logic             wr_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd_ok   = rd_i && !empty_o;
  assign wr_ok   = wr_i && (!full || rd_ok);
  assign drop_o  = wr_i && !wr_ok;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= inc(wptr_q);
      end
      if (rd_ok) begin
        rptr_q <= inc(rptr_q);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/aes_stream_wrapper.sv
// Valid/ready wrapper around a fixed-latency, non-stallable AES core.
// Credits cover in-flight plus stored beats so the FIFO cannot overflow.
module aes_stream_wrapper
  import aes_stream_pkg::*;
#(
  parameter  int CORE_LAT = AES128_LAT,
  parameter  int DEPTH    = 16,
  parameter  int TAG_W    = 8,
  parameter  int DATA_W   = DATA_W_DEF,
  localparam int OCC_W    = clog2p1(DEPTH)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [DATA_W-1:0] in_key,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] core_state,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OCC_W-1:0]  occupancy,
  output logic              err_ovf
);

  logic                      acc;
  logic                      pop;
  logic                      exit_v;
  logic                      empty;
  logic                      drop;
  logic [CORE_LAT-1:0]       vld_q;
  logic [TAG_W-1:0]          tag_q [CORE_LAT];
  logic [OCC_W-1:0]          occ_q;
  logic [OCC_W-1:0]          occ_d;
  logic                      err_q;
  logic [DATA_W+TAG_W-1:0]   rdata;

  assign in_ready   = (occ_q < OCC_W'(DEPTH));
  assign acc        = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign core_state = in_state;
  assign core_key   = in_key;
  assign exit_v     = vld_q[CORE_LAT-1];

  always_comb begin
    occ_d = occ_q;
    unique case ({acc, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Shadow of the core pipeline; clearing it orphans stale core results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_q[i] <= '0;
      end
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q[0] <= acc;
      tag_q[0] <= in_tag;
      for (int i = 1; i < CORE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      occ_q <= occ_d;
      err_q <= err_q | drop;
    end
  end

  stream_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_i    (exit_v),
    .wdata_i ({core_out, tag_q[CORE_LAT-1]}),
    .rd_i    (out_ready),
    .rdata_o (rdata),
    .empty_o (empty),
    .drop_o  (drop)
  );

  assign out_valid           = !empty;
  assign {out_data, out_tag} = rdata;
  assign occupancy           = occ_q;
  assign err_ovf             = err_q;

endmodule

// File: tb/tb_aes_stream_wrapper.sv
// Bench: four wrapper instances (DEPTH 16/4/5/13) on behavioural AES cores,
// scoreboard of accepted beats checked on every pop.
module tb_aes_stream_wrapper;

  localparam int LAT = 11;
  localparam int DEPS [4] = '{16, 4, 5, 13};
  localparam int M_ONE = 0;
  localparam int M_ZERO = 1;
  localparam int M_RND = 2;
  localparam int M_ALT = 3;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         iv   [4];
  logic         ir   [4];
  logic [127:0] ist  [4];
  logic [127:0] iky  [4];
  logic [7:0]   itg  [4];
  logic [127:0] cst  [4];
  logic [127:0] cky  [4];
  logic         ov   [4];
  logic         ordy [4];
  logic [127:0] od   [4];
  logic [7:0]   otg  [4];
  logic [4:0]   occ  [4];
  logic         eo   [4];

  logic [7:0] sbox [256];
  exp_t sbq [$];

  int nasrt = 0;
  int nfail = 0;
  int cur = 0;
  int nxt = 0;
  int nbeat = 0;
  bit mon_on = 0;
  logic [127:0] st;
  logic [127:0] ky;

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [31:0]  w [4];
    logic [31:0]  tw;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res;
    rk = key;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) b[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 4; i++) w[i] = rk[127-32*i -: 32];
      tw = {w[3][23:0], w[3][31:24]};
      tw = {sbox[tw[31:24]], sbox[tw[23:16]], sbox[tw[15:8]], sbox[tw[7:0]]};
      tw = tw ^ {rc, 24'h0};
      w[0] = w[0] ^ tw;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rk = {w[0], w[1], w[2], w[3]};
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[i] = sbox[b[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) b[q+4*c] = t[q+4*((c+q)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
          b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) b[i] = b[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : G
    localparam int D = DEPS[g];
    logic [$clog2(D+1)-1:0] o;
    logic [127:0] p [LAT];

    aes_stream_wrapper #(
      .CORE_LAT (LAT),
      .DEPTH    (D),
      .TAG_W    (8),
      .DATA_W   (128)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv[g]),
      .in_ready   (ir[g]),
      .in_state   (ist[g]),
      .in_key     (iky[g]),
      .in_tag     (itg[g]),
      .core_state (cst[g]),
      .core_key   (cky[g]),
      .core_out   (p[LAT-1]),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_data   (od[g]),
      .out_tag    (otg[g]),
      .occupancy  (o),
      .err_ovf    (eo[g])
    );

    assign occ[g] = 5'(o);

    // behavioural core: samples every edge, result LAT cycles later
    always @(posedge clk) begin
      p[0] <= aes_enc(cst[g], cky[g]);
      for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor for the active instance
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [127:0] pd;
  logic [7:0]   pt;

  always @(negedge clk) begin
    exp_t e;
    if (!rst || !mon_on) begin
      pv = 1'b0;
    end else begin
      chk("occupancy", 128'(occ[cur]), 128'(sbq.size()));
      chk("in_ready", 128'(ir[cur]), 128'(sbq.size() < DEPS[cur]));
      chk("err_ovf", 128'(eo[cur]), 128'd0);
      if (pv && !pr) begin
        chk("hold_data", od[cur], pd);
        chk("hold_tag", 128'(otg[cur]), 128'(pt));
      end
      if (ov[cur] && ordy[cur]) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", 128'(ov[cur]), 128'd0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", od[cur], e.d);
          chk("out_tag", 128'(otg[cur]), 128'(e.t));
        end
      end
      if (iv[cur] && ir[cur]) begin
        e.d = aes_enc(ist[cur], iky[cur]);
        e.t = itg[cur];
        sbq.push_back(e);
      end
      pv = ov[cur];
      pr = ordy[cur];
      pd = od[cur];
      pt = otg[cur];
    end
  end

  task automatic newbeat();
    st = {$urandom, $urandom, $urandom, $urandom};
    ky = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // one cycle of driving; entered and left at posedge+1
  task automatic step(input int mode);
    bit a;
    iv[cur]  = (nxt < nbeat);
    ist[cur] = st;
    iky[cur] = ky;
    itg[cur] = 8'(nxt);
    case (mode)
      M_ONE:   ordy[cur] = 1'b1;
      M_ZERO:  ordy[cur] = 1'b0;
      M_RND:   ordy[cur] = 1'($urandom_range(0, 1));
      default: ordy[cur] = ~ordy[cur];
    endcase
    @(negedge clk);
    a = iv[cur] && ir[cur];
    @(posedge clk);
    #1;
    if (a) begin
      nxt++;
      newbeat();
    end
    iv[cur] = 1'b0;
  endtask

  task automatic send_measure(output int n, input logic [127:0] s,
                              input logic [127:0] k, input logic [7:0] tg);
    ist[cur]  = s;
    iky[cur]  = k;
    itg[cur]  = tg;
    iv[cur]   = 1'b1;
    ordy[cur] = 1'b1;
    @(negedge clk);
    chk("meas_ready", 128'(ir[cur]), 128'd1);
    @(posedge clk);
    #1;
    iv[cur] = 1'b0;
    n = 0;
    while (!ov[cur] && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    int g2 = 0;
    iv[cur]   = 1'b0;
    ordy[cur] = 1'b1;
    while (sbq.size() != 0 && g2 < 200) begin
      @(posedge clk);
      #1;
      g2++;
    end
    chk("drain_empty", 128'(sbq.size()), 128'd0);
    chk("drain_occ", 128'(occ[cur]), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int run;
    int guard;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
      ist[k] = '0;
      iky[k] = '0;
      itg[k] = '0;
    end
    newbeat();

    // reset state
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_occ", 128'(occ[k]), 128'd0);
      chk("rst_out_valid", 128'(ov[k]), 128'd0);
      chk("rst_in_ready", 128'(ir[k]), 128'd1);
      chk("rst_err", 128'(eo[k]), 128'd0);
    end
    chk("rst_data", od[0], 128'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // FIPS-197 vector
    cur = 0;
    send_measure(n, 128'h00112233445566778899aabbccddeeff,
                 128'h000102030405060708090a0b0c0d0e0f, 8'h5a);
    chk("fips_latency", 128'(n), 128'(LAT + 1));
    chk("fips_data", od[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("fips_tag", 128'(otg[0]), 128'h5a);
    @(posedge clk);
    #1;
    drain();

    // back-to-back streaming, 40 beats
    nxt = 0;
    nbeat = 40;
    fork
      begin
        repeat (40) step(M_ONE);
      end
      begin
        @(negedge clk);
        n = 0;
        while (!ov[0] && n < 60) begin
          @(negedge clk);
          n++;
        end
        chk("stream_first_lat", 128'(n), 128'(LAT + 1));
        run = 1;
        repeat (39) begin
          @(negedge clk);
          if (ov[0]) run++;
        end
        chk("stream_run", 128'(run), 128'd40);
        @(negedge clk);
        chk("stream_end_valid", 128'(ov[0]), 128'd0);
      end
    join
    chk("stream_accepted", 128'(nxt), 128'd40);
    @(posedge clk);
    #1;
    drain();

    // reset mid-operation: 10 stored, 6 in flight
    nxt = 0;
    nbeat = 10;
    repeat (24) step(M_ZERO);
    nbeat = 16;
    repeat (6) step(M_ZERO);
    chk("pre_rst_valid", 128'(ov[0]), 128'd1);
    chk("pre_rst_occ", 128'(occ[0]), 128'd16);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_valid", 128'(ov[0]), 128'd0);
    chk("async_rst_occ", 128'(occ[0]), 128'd0);
    chk("async_rst_ready", 128'(ir[0]), 128'd1);
    sbq.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    newbeat();
    send_measure(n, st, ky, 8'hc3);
    chk("post_rst_latency", 128'(n), 128'(LAT + 1));
    chk("post_rst_tag", 128'(otg[0]), 128'hc3);
    @(posedge clk);
    #1;
    drain();

    // backpressure, DEPTH=4
    cur = 1;
    nxt = 0;
    nbeat = 12;
    newbeat();
    repeat (30) step(M_ZERO);
    chk("bp_accepted", 128'(nxt), 128'd4);
    chk("bp_occ", 128'(occ[1]), 128'd4);
    chk("bp_ready", 128'(ir[1]), 128'd0);
    chk("bp_valid", 128'(ov[1]), 128'd1);
    guard = 0;
    while (nxt < nbeat && guard < 200) begin
      step(M_ONE);
      guard++;
    end
    chk("bp_all_accepted", 128'(nxt), 128'd12);
    drain();

    // odd depth wrap, DEPTH=5
    cur = 2;
    nxt = 0;
    nbeat = 12;
    ordy[2] = 1'b0;
    guard = 0;
    while (nxt < nbeat && guard < 200) begin
      step(M_ALT);
      guard++;
    end
    chk("odd_accepted", 128'(nxt), 128'd12);
    drain();

    // random backpressure, DEPTH=CORE_LAT+2
    cur = 3;
    nxt = 0;
    nbeat = 1000;
    guard = 0;
    while (nxt < nbeat && guard < 8000) begin
      step(M_RND);
      guard++;
    end
    chk("rnd_accepted", 128'(nxt), 128'd1000);
    drain();

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
